// File: rtl/ext_mem_bridge.sv
// ext_mem_bridge
// Bridges a 16-bit CPU word interface to an 8-bit multiplexed address/data
// bus. Each transaction sends two address phases (high byte, then low byte)
// with ALE asserted. It then runs one or two byte-wide data phases, each
// gated by a device acknowledge and guarded by a wait-cycle timeout.
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   adr, memOut           CPU word address / write data (sampled on accept)
//   memwrite_a/b          byte write strobes (low / high byte)
//   memread               full-word read request
//   memdata               read data returned to the CPU (held between reads)
//   busy, done, err       transaction status; err is qualified by done
//   ext_ad_out/oe/in      multiplexed bus output value, drive enable, input
//   ext_ale               address latch enable
//   ext_we_n, ext_oe_n    active-low write / read strobes
//   ext_bsel              byte select (1 = high byte)
//   ext_ack               device acknowledge for the current data phase
module ext_mem_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] adr,
  input  logic [15:0] memOut,
  input  logic        memwrite_a,
  input  logic        memwrite_b,
  input  logic        memread,
  output logic [15:0] memdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  ext_ad_out,
  output logic        ext_ad_oe,
  input  logic [7:0]  ext_ad_in,
  output logic        ext_ale,
  output logic        ext_we_n,
  output logic        ext_oe_n,
  output logic        ext_bsel,
  input  logic        ext_ack
);

  typedef enum logic [2:0] {
    IDLE, ADDR_HI, ADDR_LO, WR_HI, WR_LO, RD_HI, RD_LO, DONE
  } state_t;

  localparam logic [8:0] TO_LIM = 9'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] adr_q, adr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wa_q, wa_d;
  logic        wb_q, wb_d;
  logic [15:0] memdata_q, memdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  ad_out_q, ad_out_d;
  logic        ad_oe_q, ad_oe_d;
  logic        ale_q, ale_d;
  logic        we_n_q, we_n_d;
  logic        oe_n_q, oe_n_d;
  logic        bsel_q, bsel_d;

  logic        wait_exp;
  logic        timeout;

  // The current low-ack cycle is the TIMEOUT-th one, so abort this phase.
  assign wait_exp = (9'(cnt_q) + 9'd1) >= TO_LIM;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    wdata_d   = wdata_q;
    wa_d      = wa_q;
    wb_d      = wb_q;
    memdata_d = memdata_q;
    timeout   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (memread || memwrite_a || memwrite_b) begin
          adr_d   = adr;
          wdata_d = memOut;
          wa_d    = memwrite_a;
          wb_d    = memwrite_b;
          state_d = ADDR_HI;
        end
      end
      ADDR_HI: state_d = ADDR_LO;
      ADDR_LO: begin
        cnt_d = 8'd0;
        // Any write strobe selects the write path; a companion read is dropped.
        if (wb_q)      state_d = WR_HI;
        else if (wa_q) state_d = WR_LO;
        else           state_d = RD_HI;
      end
      WR_HI, WR_LO, RD_HI, RD_LO: begin
        if (ext_ack) begin
          cnt_d = 8'd0;
          case (state_q)
            WR_HI:   state_d = wa_q ? WR_LO : DONE;
            RD_HI: begin
              memdata_d[15:8] = ext_ad_in;
              state_d         = RD_LO;
            end
            RD_LO: begin
              memdata_d[7:0] = ext_ad_in;
              state_d        = DONE;
            end
            default: state_d = DONE;
          endcase
        end else if (wait_exp) begin
          cnt_d   = 8'd0;
          timeout = 1'b1;
          state_d = DONE;
          // A read that times out returns all ones, even if one byte arrived.
          if (state_q == RD_HI || state_q == RD_LO) memdata_d = 16'hFFFF;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that they are registered
  // alongside the state and are aligned with it.
  always_comb begin
    busy_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    ad_out_d = 8'h00;
    ad_oe_d  = 1'b0;
    ale_d    = 1'b0;
    we_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    bsel_d   = 1'b0;

    unique case (state_d)
      ADDR_HI: begin
        busy_d   = 1'b1;
        ad_out_d = adr_d[15:8];
        ad_oe_d  = 1'b1;
        ale_d    = 1'b1;
      end
      ADDR_LO: begin
        busy_d   = 1'b1;
        ad_out_d = adr_d[7:0];
        ad_oe_d  = 1'b1;
        ale_d    = 1'b1;
      end
      WR_HI: begin
        busy_d   = 1'b1;
        ad_out_d = wdata_d[15:8];
        ad_oe_d  = 1'b1;
        we_n_d   = 1'b0;
        bsel_d   = 1'b1;
      end
      WR_LO: begin
        busy_d   = 1'b1;
        ad_out_d = wdata_d[7:0];
        ad_oe_d  = 1'b1;
        we_n_d   = 1'b0;
      end
      RD_HI: begin
        busy_d = 1'b1;
        oe_n_d = 1'b0;
        bsel_d = 1'b1;
      end
      RD_LO: begin
        busy_d = 1'b1;
        oe_n_d = 1'b0;
      end
      DONE: begin
        done_d = 1'b1;
        err_d  = timeout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      wa_q      <= 1'b0;
      wb_q      <= 1'b0;
      memdata_q <= 16'h0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ad_out_q  <= 8'h00;
      ad_oe_q   <= 1'b0;
      ale_q     <= 1'b0;
      we_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      bsel_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wa_q      <= wa_d;
      wb_q      <= wb_d;
      memdata_q <= memdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ad_out_q  <= ad_out_d;
      ad_oe_q   <= ad_oe_d;
      ale_q     <= ale_d;
      we_n_q    <= we_n_d;
      oe_n_q    <= oe_n_d;
      bsel_q    <= bsel_d;
    end
  end

  // Request payload: only meaningful once a request has been accepted.
  always_ff @(posedge clk) begin
    adr_q   <= adr_d;
    wdata_q <= wdata_d;
  end

  assign memdata    = memdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign ext_ad_out = ad_out_q;
  assign ext_ad_oe  = ad_oe_q;
  assign ext_ale    = ale_q;
  assign ext_we_n   = we_n_q;
  assign ext_oe_n   = oe_n_q;
  assign ext_bsel   = bsel_q;

endmodule
